ov7670_config_sequencer: RTL

// Reads the OV7670 static register table from the config ROM and turns it into

---
 rtl/ov7670_config_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register table in ROM and issues one SCCB write per entry.
// Entry 16'hFFF0 inserts a fixed delay; 16'hFFFF (or running past 8'hFF) ends the table.
module ov7670_config_sequencer #(
  parameter int         CLK_FREQ = 25_000_000,
  parameter int         DELAY_MS = 10,
  parameter logic [7:0] CAM_ADDR = 8'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_dev,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  output logic        busy,
  output logic        done
);

  localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_LO,
    WAIT_HI,
    DELAY,
    ADVANCE,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign sccb_dev = CAM_ADDR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      sccb_start <= 1'b0;
      sccb_reg   <= '0;
      sccb_val   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
    end else begin
      sccb_start <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_dout == 16'hFFFF) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (rom_dout == 16'hFFF0) begin
            cnt   <= '0;
            state <= DELAY;
          end else begin
            sccb_reg <= rom_dout[15:8];
            sccb_val <= rom_dout[7:0];
            state    <= SEND;
          end
        end
        SEND: begin
          if (sccb_ready) begin
            sccb_start <= 1'b1;
            state      <= WAIT_LO;
          end
        end
        // master must first acknowledge by dropping ready, then finish
        WAIT_LO: if (!sccb_ready) state <= WAIT_HI;
        WAIT_HI: if (sccb_ready) state <= ADVANCE;
        DELAY: begin
          if (cnt == CNT_LAST) state <= ADVANCE;
          else cnt <= cnt + CW'(1);
        end
        ADVANCE: begin
          if (rom_addr == 8'hFF) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rom_addr <= rom_addr + 8'd1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
